z16_boot_loader: RTL and testbench
==================================

Name: z16_boot_loader

Overview:
- Byte-stream program loader upstream of the Z16 core's instruction memory.
- Receives a framed image over a valid/ready byte interface (typically from a UART RX) and assembles little-endian 16-bit words.
- Writes the words into instruction memory starting at byte address 0x0000.
- Holds the core in reset until the image is fully and correctly loaded.

Parameters:
- IMEM_WORDS, 256, instruction memory capacity in 16-bit words; larger lengths are rejected.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_rx_data  in  8  incoming byte
- i_rx_valid  in  1  i_rx_data valid
- o_rx_ready  out  1  loader accepts byte this cycle
- o_imem_waddr  out  16  instruction memory byte address (always even)
- o_imem_wdata  out  16  instruction word
- o_imem_wen  out  1  single-cycle write strobe
- o_cpu_rst  out  1  reset to core, active-high
- o_busy  out  1  frame in progress (state not SYNC/DONE/ERR)
- o_done  out  1  image loaded, core released
- o_err  out  1  frame rejected; sticky until i_rst

Behaviour:
- Byte transfer: a byte is accepted on a rising edge where i_rx_valid && o_rx_ready.
- o_rx_ready is combinational:
  - 1 in SYNC, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CSUM.
  - 0 in DONE and ERR.
- Reset values: state=SYNC, o_imem_wen=0, o_imem_waddr=0, o_imem_wdata=0, o_cpu_rst=1, o_done=0, o_err=0, o_busy=0, word counter=0, length=0.
- States and transitions:
  - SYNC: accepted byte == SYNC_BYTE -> LEN_LO; any other byte is discarded and the state stays SYNC.
  - LEN_LO: latch length[7:0] -> LEN_HI.
  - LEN_HI: latch length[15:8].
    - If {byte, length[7:0]} == 0 -> DONE.
    - If it exceeds IMEM_WORDS -> ERR.
    - Otherwise clear the word counter -> DATA_LO.
  - DATA_LO: latch low byte -> DATA_HI.
  - DATA_HI: on accept, register a write for the next cycle: o_imem_wen=1, o_imem_wdata={byte, low}, o_imem_waddr={counter[14:0],1'b0}. Increment the counter.
    - If counter+1 == length -> DONE (or CSUM when the optional feature is on).
    - Otherwise -> DATA_LO.
  - DONE: o_done=1; terminal until i_rst.
  - ERR: o_err=1; terminal until i_rst. o_cpu_rst stays 1.
- Write latency: o_imem_wen pulses exactly one cycle, in the cycle after the high byte is accepted. No write occurs in any other state.
- Core release: o_cpu_rst is registered and falls one cycle after o_done first rises, so the final write has landed before the core fetches from PC 0x0000.
- Counter and address: 16-bit counter, no wrap possible because length <= IMEM_WORDS is enforced.
- Bubbles: i_rx_valid gaps of any length are legal in every state; the state and partial bytes are held.
- Reset mid-frame: returns to SYNC with o_cpu_rst=1. Instruction memory contents already written are not cleared.
- Simultaneous i_rst and byte accept: reset wins; the byte is dropped.

Optional Feature:
- Macro: Z16_BOOT_CHECKSUM_EN.
- Defined:
  - A running 8-bit XOR of all DATA_LO/DATA_HI bytes is kept, cleared on entry to DATA_LO from LEN_HI.
  - After the last word, state CSUM accepts one byte: equal to the running XOR -> DONE, else -> ERR.
  - A zero-length frame still requires a CSUM byte of 8'h00.
  - Words are written regardless of the checksum outcome; only core release is gated.
- Undefined: no CSUM state; DONE is entered directly after the last DATA_HI.

Decomposition:
- Package z16_boot_pkg:
  - State enum (SYNC, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CSUM, DONE, ERR).
  - SYNC_BYTE default.
  - Helper for byte-pair to word assembly.
- Sub-module: none. The FSM, counter and write register form a single block. The checksum accumulator stays inline, under the macro.

Test Plan:
- Nominal frame A5 02 00 34 12 78 56, no gaps -> writes (0x0000, 0x1234) then (0x0002, 0x5678); o_done=1; o_cpu_rst falls one cycle later; o_rx_ready=0 afterwards.
- Junk then frame: FF 00 A5 01 00 CD AB -> junk discarded; one write (0x0000, 0xABCD); o_done=1.
- Length overflow: A5 01 01 (257 > 256) -> o_err=1, no writes, o_cpu_rst held 1, o_rx_ready=0.
- Random i_rx_valid gaps on the nominal frame -> identical write sequence and data; o_imem_wen never asserts in a gap.
- i_rst asserted after the first write of a 2-word frame, then a full 1-word frame A5 01 00 EF BE -> write (0x0000, 0xBEEF); o_done=1.
- With Z16_BOOT_CHECKSUM_EN:
  - Frame A5 01 00 34 12 26 -> done.
  - Same frame with final byte 27 -> o_err=1, write still seen, o_cpu_rst stays 1.

Source files
------------

// File: rtl/z16_boot_pkg.sv
// Shared types for the Z16 boot loader: FSM state encoding,
// default frame sync marker and byte-pair word assembly.
package z16_boot_pkg;

  typedef enum logic [2:0] {
    SYNC,
    LEN_LO,
    LEN_HI,
    DATA_LO,
    DATA_HI,
    CSUM,
    DONE,
    ERR
  } boot_state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Image bytes arrive little-endian: low byte first.
  function automatic logic [15:0] mk_word(
    input logic [7:0] hi,
    input logic [7:0] lo
  );
    return {hi, lo};
  endfunction

endpackage

// File: rtl/z16_boot_loader.sv
// Z16 boot loader: receives a framed image over a valid/ready byte
// stream and writes 16-bit words to instruction memory from 0x0000,
// holding the core in reset until the image is loaded.
// Ports: i_clk/i_rst (sync, active-high), i_rx_data/i_rx_valid/
// o_rx_ready byte input, o_imem_waddr/o_imem_wdata/o_imem_wen write
// port, o_cpu_rst core reset, o_busy/o_done/o_err status.
// Frame: SYNC_BYTE, len lo, len hi, len x (lo, hi) [, xor checksum].
// Optional: define Z16_BOOT_CHECKSUM_EN to require the trailing
// XOR checksum byte before the core is released.
module z16_boot_loader
  import z16_boot_pkg::*;
#(
  parameter int         IMEM_WORDS = 256,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic [15:0] o_imem_waddr,
  output logic [15:0] o_imem_wdata,
  output logic        o_imem_wen,
  output logic        o_cpu_rst,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam logic [15:0] MAX_LEN = 16'(IMEM_WORDS);

  boot_state_t state;
  logic [15:0] len;
  logic [15:0] cnt;
  logic [7:0]  lo_byte;
`ifdef Z16_BOOT_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  logic        acc;
  logic [15:0] len_full;
  logic [15:0] cnt_nxt;

  assign o_rx_ready = (state != DONE) && (state != ERR);
  assign o_busy     = (state != SYNC) && o_rx_ready;
  assign acc        = i_rx_valid && o_rx_ready;
  assign len_full   = {i_rx_data, len[7:0]};
  assign cnt_nxt    = cnt + 16'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= SYNC;
      len          <= '0;
      cnt          <= '0;
      lo_byte      <= '0;
      o_imem_wen   <= 1'b0;
      o_imem_waddr <= '0;
      o_imem_wdata <= '0;
      o_cpu_rst    <= 1'b1;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
`ifdef Z16_BOOT_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      o_imem_wen <= 1'b0;
      // Release one cycle after done so the last write lands first.
      if (o_done) o_cpu_rst <= 1'b0;
      if (acc) begin
        unique case (state)
          SYNC: begin
            if (i_rx_data == SYNC_BYTE) state <= LEN_LO;
          end
          LEN_LO: begin
            len[7:0] <= i_rx_data;
            state    <= LEN_HI;
          end
          LEN_HI: begin
            len[15:8] <= i_rx_data;
            cnt       <= '0;
`ifdef Z16_BOOT_CHECKSUM_EN
            csum      <= '0;
`endif
            if (len_full > MAX_LEN) begin
              state <= ERR;
              o_err <= 1'b1;
            end else if (len_full == 16'd0) begin
`ifdef Z16_BOOT_CHECKSUM_EN
              state  <= CSUM;
`else
              state  <= DONE;
              o_done <= 1'b1;
`endif
            end else begin
              state <= DATA_LO;
            end
          end
          DATA_LO: begin
            lo_byte <= i_rx_data;
`ifdef Z16_BOOT_CHECKSUM_EN
            csum    <= csum ^ i_rx_data;
`endif
            state   <= DATA_HI;
          end
          DATA_HI: begin
            o_imem_wen   <= 1'b1;
            o_imem_wdata <= mk_word(i_rx_data, lo_byte);
            o_imem_waddr <= {cnt[14:0], 1'b0};
            cnt          <= cnt_nxt;
`ifdef Z16_BOOT_CHECKSUM_EN
            csum         <= csum ^ i_rx_data;
`endif
            if (cnt_nxt == len) begin
`ifdef Z16_BOOT_CHECKSUM_EN
              state  <= CSUM;
`else
              state  <= DONE;
              o_done <= 1'b1;
`endif
            end else begin
              state <= DATA_LO;
            end
          end
          CSUM: begin
`ifdef Z16_BOOT_CHECKSUM_EN
            if (i_rx_data == csum) begin
              state  <= DONE;
              o_done <= 1'b1;
            end else begin
              state <= ERR;
              o_err <= 1'b1;
            end
`else
            state <= ERR;
            o_err <= 1'b1;
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_z16_boot_loader.sv
// Self-checking bench for z16_boot_loader: framed images are driven
// byte by byte and expected writes are scoreboarded against the DUT.
module tb_z16_boot_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] waddr;
  logic [15:0] wdata;
  logic        wen;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [15:0] words[$];
  bit          wr_due = 1'b0;
  bit          mon_en = 1'b0;

  z16_boot_loader dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .o_rx_ready   (rx_ready),
    .o_imem_waddr (waddr),
    .o_imem_wdata (wdata),
    .o_imem_wen   (wen),
    .o_cpu_rst    (cpu_rst),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: a write must appear exactly in the cycle after
  // a high data byte is accepted, with the scoreboarded addr/data.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (wen !== wr_due) begin
        failures++;
        $display("FAIL wen_timing: got %b want %b at %0t",
                 wen, wr_due, $time);
      end
      wr_due = 1'b0;
      if (wen === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL write_unexpected: addr %h data %h",
                   waddr, wdata);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if ({waddr, wdata} !== e) begin
            failures++;
            $display("FAIL write_data: got %h/%h want %h/%h",
                     waddr, wdata, e[31:16], e[15:0]);
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit hi,
                           input bit gaps);
    if (gaps) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    if (hi) wr_due = 1'b1;
  endtask

  // Sends sync, length, the words queue and (when enabled) the
  // checksum XOR-ed with csum_bad.
  task automatic send_frame(input logic [15:0] len, input bit gaps,
                            input logic [7:0] csum_bad);
    logic [7:0] cs;
    cs = 8'h00;
    send_byte(8'hA5, 1'b0, gaps);
    send_byte(len[7:0], 1'b0, gaps);
    send_byte(len[15:8], 1'b0, gaps);
    for (int i = 0; i < words.size(); i++) begin
      logic [15:0] w;
      logic [15:0] a;
      w = words[i];
      a = 16'(i * 2);
      cs = cs ^ w[7:0] ^ w[15:8];
      send_byte(w[7:0], 1'b0, gaps);
      exp_q.push_back({a, w});
      send_byte(w[15:8], 1'b1, gaps);
    end
`ifdef Z16_BOOT_CHECKSUM_EN
    send_byte(cs ^ csum_bad, 1'b0, gaps);
`else
    if (csum_bad != 8'h00) cs = 8'h00;
`endif
  endtask

  task automatic check_done_release(input string nm);
    checks++;
    if ({done, err, cpu_rst} !== 3'b101) begin
      failures++;
      $display("FAIL %s_done: done/err/cpu_rst got %b%b%b want 101",
               nm, done, err, cpu_rst);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({cpu_rst, rx_ready, busy} !== 3'b000) begin
      failures++;
      $display("FAIL %s_release: cpu_rst/ready/busy got %b%b%b want 000",
               nm, cpu_rst, rx_ready, busy);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_writes: %0d pending want 0", nm, exp_q.size());
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rst      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rx_ready, wen, cpu_rst, busy, done, err} !== 6'b101000 ||
        waddr !== 16'h0 || wdata !== 16'h0) begin
      failures++;
      $display("FAIL reset: rdy/wen/crst/busy/done/err %b%b%b%b%b%b %h %h",
               rx_ready, wen, cpu_rst, busy, done, err, waddr, wdata);
    end
    rst    = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_nominal();
    words = '{16'h1234, 16'h5678};
    send_frame(16'd2, 1'b0, 8'h00);
    check_done_release("nominal");
    apply_reset();
  endtask

  task automatic test_junk();
    send_byte(8'hFF, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL junk_busy: got %b want 0", busy);
    end
    words = '{16'hABCD};
    send_frame(16'd1, 1'b0, 8'h00);
    check_done_release("junk");
    apply_reset();
  endtask

  task automatic test_overflow();
    words = {};
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({err, done, cpu_rst, rx_ready, busy} !== 5'b10100) begin
      failures++;
      $display("FAIL overflow: err/done/crst/rdy/busy got %b%b%b%b%b want 10100",
               err, done, cpu_rst, rx_ready, busy);
    end
    apply_reset();
    // Exactly IMEM_WORDS is still accepted as a length.
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    checks++;
    if ({err, busy} !== 2'b01) begin
      failures++;
      $display("FAIL len_max: err/busy got %b%b want 01", err, busy);
    end
    apply_reset();
  endtask

  task automatic test_zero_len();
    words = {};
    send_frame(16'd0, 1'b0, 8'h00);
    check_done_release("zero_len");
    apply_reset();
  endtask

  task automatic test_gaps();
    for (int r = 0; r < 4; r++) begin
      words = '{16'h1234, 16'h5678};
      send_frame(16'd2, 1'b1, 8'h00);
      check_done_release("gaps");
      apply_reset();
    end
  endtask

  task automatic test_reset_mid();
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0);
    exp_q.push_back({16'h0000, 16'h2211});
    send_byte(8'h22, 1'b1, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({cpu_rst, busy, done, err} !== 4'b1000 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL reset_mid: crst/busy/done/err %b%b%b%b pend %0d",
               cpu_rst, busy, done, err, exp_q.size());
    end
    // Byte accepted in the same cycle as reset is dropped.
    rst      = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    rx_valid = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_wins: busy got %b want 0", busy);
    end
    words = '{16'hBEEF};
    send_frame(16'd1, 1'b0, 8'h00);
    check_done_release("after_reset");
    apply_reset();
  endtask

`ifdef Z16_BOOT_CHECKSUM_EN
  task automatic test_checksum();
    words = '{16'h1234};
    send_frame(16'd1, 1'b0, 8'h01);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({err, done, cpu_rst, exp_q.size() == 0} !== 4'b1011) begin
      failures++;
      $display("FAIL csum_bad: err/done/crst/drained %b%b%b%b want 1011",
               err, done, cpu_rst, exp_q.size() == 0);
    end
    apply_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_junk();
    test_overflow();
    test_zero_len();
    test_gaps();
    test_reset_mid();
`ifdef Z16_BOOT_CHECKSUM_EN
    test_checksum();
`endif
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time limit reached");
    $fatal(1, "timeout");
  end

endmodule
